// File: rtl/stopwatch_counter_if.sv
// Signal bundle between the stopwatch core and its surroundings: divider ticks,
// button/switch levels in, BCD MM:SS digits, mode and rollover out.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       btn_pause;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode;
  logic       rollover;

  modport master (
    output tick_1hz, tick_2hz, btn_pause, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, mode, rollover
  );

  modport slave (
    input  tick_1hz, tick_2hz, btn_pause, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, mode, rollover
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause/adjust modes driven by sampled divider ticks.
// Optional macro STOPWATCH_INPUT_SYNC_EN adds a two-flop synchronizer on all inputs.
module stopwatch_counter (
  input  logic                clk_in,
  input  logic                rst_n,
  stopwatch_counter_if.slave  sw
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_PAUSE   = 2'b01;
  localparam logic [1:0] ST_ADJ_MIN = 2'b10;
  localparam logic [1:0] ST_ADJ_SEC = 2'b11;

  logic [4:0] raw_in;
  logic [4:0] in_vec;
  logic [2:0] prev_q;
  logic [1:0] arm_cnt;
  logic       armed;
  logic       e_1hz;
  logic       e_2hz;
  logic       e_btn;
  logic       in_adj;
  logic       in_sel;

  logic       pause_q;
  logic       pause_n;
  logic [1:0] state;
  logic [1:0] mode_q;
  logic [1:0] mode_n;
  logic       roll_q;
  logic       roll_n;
  logic [3:0] min_t_q, min_o_q, sec_t_q, sec_o_q;
  logic [3:0] min_t_n, min_o_n, sec_t_n, sec_o_n;

  assign raw_in = {sw.tick_1hz, sw.tick_2hz, sw.btn_pause, sw.adj, sw.sel};

`ifdef STOPWATCH_INPUT_SYNC_EN
  localparam logic [1:0] ARM_CYCLES = 2'd3;

  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_vec = sync2_q;
`else
  localparam logic [1:0] ARM_CYCLES = 2'd1;

  assign in_vec = raw_in;
`endif

  // Edges stay masked until the sampled levels after reset have reached the
  // previous-sample register, so a level already high at release is not an edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= '0;
      prev_q  <= '0;
    end else begin
      if (arm_cnt != ARM_CYCLES) arm_cnt <= arm_cnt + 2'd1;
      prev_q <= in_vec[4:2];
    end
  end

  assign armed  = (arm_cnt == ARM_CYCLES);
  assign e_1hz  = armed & in_vec[4] & ~prev_q[2];
  assign e_2hz  = armed & in_vec[3] & ~prev_q[1];
  assign e_btn  = armed & in_vec[2] & ~prev_q[0];
  assign in_adj = in_vec[1];
  assign in_sel = in_vec[0];

  // The tick in this cycle is judged with the pause flag from before any toggle.
  assign state   = in_adj ? (in_sel ? ST_ADJ_SEC : ST_ADJ_MIN)
                          : (pause_q ? ST_PAUSE : ST_RUN);
  assign pause_n = pause_q ^ e_btn;
  assign mode_n  = in_adj ? {1'b1, in_sel} : {1'b0, pause_n};

  always_comb begin
    min_t_n = min_t_q;
    min_o_n = min_o_q;
    sec_t_n = sec_t_q;
    sec_o_n = sec_o_q;
    roll_n  = 1'b0;
    case (state)
      ST_RUN: begin
        if (e_1hz) begin
          if (sec_o_q != 4'd9) begin
            sec_o_n = sec_o_q + 4'd1;
          end else begin
            sec_o_n = 4'd0;
            if (sec_t_q != 4'd5) begin
              sec_t_n = sec_t_q + 4'd1;
            end else begin
              sec_t_n = 4'd0;
              if (min_o_q != 4'd9) begin
                min_o_n = min_o_q + 4'd1;
              end else begin
                min_o_n = 4'd0;
                if (min_t_q != 4'd5) begin
                  min_t_n = min_t_q + 4'd1;
                end else begin
                  min_t_n = 4'd0;
                  roll_n  = 1'b1;
                end
              end
            end
          end
        end
      end
      ST_ADJ_MIN: begin
        if (e_2hz) begin
          if (min_o_q != 4'd9) begin
            min_o_n = min_o_q + 4'd1;
          end else begin
            min_o_n = 4'd0;
            min_t_n = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
          end
        end
      end
      ST_ADJ_SEC: begin
        if (e_2hz) begin
          if (sec_o_q != 4'd9) begin
            sec_o_n = sec_o_q + 4'd1;
          end else begin
            sec_o_n = 4'd0;
            sec_t_n = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      min_t_q <= '0;
      min_o_q <= '0;
      sec_t_q <= '0;
      sec_o_q <= '0;
      pause_q <= 1'b0;
      mode_q  <= ST_RUN;
      roll_q  <= 1'b0;
    end else begin
      min_t_q <= min_t_n;
      min_o_q <= min_o_n;
      sec_t_q <= sec_t_n;
      sec_o_q <= sec_o_n;
      pause_q <= pause_n;
      mode_q  <= mode_n;
      roll_q  <= roll_n;
    end
  end

  assign sw.min_tens = min_t_q;
  assign sw.min_ones = min_o_q;
  assign sw.sec_tens = sec_t_q;
  assign sw.sec_ones = sec_o_q;
  assign sw.mode     = mode_q;
  assign sw.rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus random
// stimulus against a seconds-count reference model (honours STOPWATCH_INPUT_SYNC_EN).
module tb_stopwatch_counter;

`ifdef STOPWATCH_INPUT_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  stopwatch_counter_if sw_bus ();

  stopwatch_counter dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sw     (sw_bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // Reference state: elapsed seconds as one integer, plus pause flag and
  // the sampled-input history needed for edge detection.
  int         m_total;
  logic       m_pause;
  logic       m_roll;
  logic [1:0] m_mode;
  logic [2:0] m_prev;
  logic [4:0] m_s1;
  logic [4:0] m_s2;
  int         m_since;

  function automatic logic [15:0] to_bcd(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {sw_bus.min_tens, sw_bus.min_ones, sw_bus.sec_tens, sw_bus.sec_ones};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic model_reset();
    m_total = 0;
    m_pause = 1'b0;
    m_roll  = 1'b0;
    m_mode  = 2'b00;
    m_prev  = '0;
    m_s1    = '0;
    m_s2    = '0;
    m_since = 0;
  endtask

  // One clock: advance the model by the edge's input values, then compare.
  task automatic step();
    logic [4:0] raw;
    logic [4:0] used;
    logic       armed;
    logic       e1, e2, eb;
    int         m, s;
    raw = {sw_bus.tick_1hz, sw_bus.tick_2hz, sw_bus.btn_pause, sw_bus.adj, sw_bus.sel};
    @(posedge clk_in);
    if (DLY == 0) begin
      used = raw;
    end else begin
      used = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
    end
    armed = (m_since > DLY);
    if (!armed) m_since++;
    e1 = armed && used[4] && !m_prev[2];
    e2 = armed && used[3] && !m_prev[1];
    eb = armed && used[2] && !m_prev[0];
    m_prev = used[4:2];
    m_roll = 1'b0;
    if (used[1]) begin
      if (e2) begin
        m = m_total / 60;
        s = m_total % 60;
        if (used[0]) s = (s + 1) % 60;
        else         m = (m + 1) % 60;
        m_total = m * 60 + s;
      end
    end else if (!m_pause && e1) begin
      m_roll  = (m_total == 3599);
      m_total = (m_total + 1) % 3600;
    end
    if (eb) m_pause = !m_pause;
    m_mode = used[1] ? {1'b1, used[0]} : {1'b0, m_pause};
    #1;
    check_output("digits", dut_digits(), to_bcd(m_total));
    check_output("mode", 16'(sw_bus.mode), 16'(m_mode));
    check_output("rollover", 16'(sw_bus.rollover), 16'(m_roll));
  endtask

  task automatic flush();
    repeat (DLY + 2) step();
  endtask

  task automatic pulse_1hz(input int n);
    for (int i = 0; i < n; i++) begin
      sw_bus.tick_1hz = 1'b1; step();
      sw_bus.tick_1hz = 1'b0; step();
    end
  endtask

  task automatic pulse_2hz(input int n);
    for (int i = 0; i < n; i++) begin
      sw_bus.tick_2hz = 1'b1; step();
      sw_bus.tick_2hz = 1'b0; step();
    end
  endtask

  task automatic press();
    sw_bus.btn_pause = 1'b1; step();
    sw_bus.btn_pause = 1'b0; step();
    flush();
  endtask

  task automatic apply_stimulus(input logic a, input logic s);
    sw_bus.adj = a;
    sw_bus.sel = s;
    flush();
  endtask

  initial begin
    int n;
    sw_bus.tick_1hz  = 1'b0;
    sw_bus.tick_2hz  = 1'b0;
    sw_bus.btn_pause = 1'b0;
    sw_bus.adj       = 1'b0;
    sw_bus.sel       = 1'b0;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    check_output("reset_digits", dut_digits(), 16'h0000);
    check_output("reset_mode", 16'(sw_bus.mode), 16'h0000);
    check_output("reset_roll", 16'(sw_bus.rollover), 16'h0000);
    repeat (2) @(posedge clk_in);
    #3 rst_n = 1'b1;
    model_reset();
    flush();

    pulse_1hz(60);
    flush();
    check_output("run_60", dut_digits(), 16'h0100);

    apply_stimulus(1'b1, 1'b0);
    pulse_2hz(58);
    apply_stimulus(1'b1, 1'b1);
    pulse_2hz(59);
    apply_stimulus(1'b0, 1'b0);
    check_output("at_5959", dut_digits(), 16'h5959);
    sw_bus.tick_1hz = 1'b1;
    repeat (DLY + 1) step();
    check_output("wrap_digits", dut_digits(), 16'h0000);
    check_output("wrap_roll", 16'(sw_bus.rollover), 16'h0001);
    step();
    check_output("roll_one_cycle", 16'(sw_bus.rollover), 16'h0000);
    sw_bus.tick_1hz = 1'b0;
    flush();

    pulse_1hz(5);
    flush();
    press();
    pulse_1hz(3);
    flush();
    check_output("paused_hold", dut_digits(), 16'h0005);
    check_output("paused_mode", 16'(sw_bus.mode), 16'h0001);
    press();
    pulse_1hz(1);
    flush();
    check_output("resumed", dut_digits(), 16'h0006);
    check_output("resumed_mode", 16'(sw_bus.mode), 16'h0000);

    apply_stimulus(1'b1, 1'b0);
    pulse_2hz(58);
    apply_stimulus(1'b1, 1'b1);
    pulse_2hz(24);
    apply_stimulus(1'b1, 1'b0);
    check_output("at_5830", dut_digits(), 16'h5830);
    pulse_2hz(3);
    flush();
    check_output("adj_min_wrap", dut_digits(), 16'h0130);
    check_output("adj_min_mode", 16'(sw_bus.mode), 16'h0002);
    pulse_2hz(59);
    apply_stimulus(1'b1, 1'b1);
    pulse_2hz(28);
    flush();
    check_output("at_0058", dut_digits(), 16'h0058);
    pulse_2hz(3);
    flush();
    check_output("adj_sec_wrap", dut_digits(), 16'h0001);
    check_output("adj_sec_mode", 16'(sw_bus.mode), 16'h0003);
    apply_stimulus(1'b0, 1'b0);

    pulse_1hz(9);
    flush();
    sw_bus.tick_1hz  = 1'b1;
    sw_bus.btn_pause = 1'b1;
    step();
    sw_bus.tick_1hz  = 1'b0;
    sw_bus.btn_pause = 1'b0;
    flush();
    check_output("same_cycle_digits", dut_digits(), 16'h0011);
    check_output("same_cycle_mode", 16'(sw_bus.mode), 16'h0001);
    press();

    sw_bus.tick_1hz = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (dut_digits() == 16'h0011 && n < 10);
    check_output("tick_latency", 16'(n), 16'(DLY + 1));
    sw_bus.tick_1hz = 1'b0;
    flush();

    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 60 && (m_total / 60) != 12; i++) begin
      pulse_2hz(1);
      flush();
    end
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 60 && (m_total % 60) != 34; i++) begin
      pulse_2hz(1);
      flush();
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("at_1234", dut_digits(), 16'h1234);
    #3 rst_n = 1'b0;
    #1;
    check_output("async_rst_digits", dut_digits(), 16'h0000);
    check_output("async_rst_mode", 16'(sw_bus.mode), 16'h0000);
    check_output("async_rst_roll", 16'(sw_bus.rollover), 16'h0000);
    sw_bus.tick_1hz = 1'b1;
    repeat (2) @(posedge clk_in);
    #3 rst_n = 1'b1;
    model_reset();
    repeat (4) step();
    check_output("no_incr_after_rst", dut_digits(), 16'h0000);
    sw_bus.tick_1hz = 1'b0;
    step();
    sw_bus.tick_1hz = 1'b1;
    flush();
    check_output("first_real_edge", dut_digits(), 16'h0001);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0)  sw_bus.tick_1hz  = ~sw_bus.tick_1hz;
      if ($urandom_range(2) == 0)  sw_bus.tick_2hz  = ~sw_bus.tick_2hz;
      if ($urandom_range(9) == 0)  sw_bus.btn_pause = ~sw_bus.btn_pause;
      if ($urandom_range(24) == 0) sw_bus.adj       = ~sw_bus.adj;
      if ($urandom_range(11) == 0) sw_bus.sel       = ~sw_bus.sel;
      step();
    end

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have port clk_in, input, 1, 100 MHz system clock; sole clock, all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port tick_1hz, input, 1, 1 Hz square wave from clock divider, sampled as data in clk_in domain.
REQ-004 SHALL have port tick_2hz, input, 1, 2 Hz square wave from clock divider, sampled as data.
REQ-005 SHALL have port btn_pause, input, 1, debounced pause button level; each rising edge toggles the pause flag.
REQ-006 SHALL have port adj, input, 1, level; 1 selects adjust mode.
REQ-007 SHALL have port sel, input, 1, adjust field select: 0 = minutes, 1 = seconds.
REQ-008 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 each, BCD digits of MM:SS.
REQ-009 SHALL have port mode, output, 2, current state: 00 RUN, 01 PAUSE, 10 ADJ_MIN, 11 ADJ_SEC.
REQ-010 SHALL have port rollover, output, 1, one-cycle pulse when 59:59 -> 00:00 in RUN.

Function
REQ-011 SHALL edge-detect each of tick_1hz, tick_2hz and btn_pause against a registered previous sample; an edge is "input high now, previous sample low".
REQ-012 SHALL hold a pause flag that toggles on every btn_pause edge, in every state, including ADJ_MIN and ADJ_SEC.
REQ-013 SHALL derive the state each cycle: adj=1 and sel=0 -> ADJ_MIN; adj=1 and sel=1 -> ADJ_SEC; adj=0 -> PAUSE if the pause flag is set, else RUN.
REQ-014 SHALL, in RUN, increment MM:SS by one second on each tick_1hz edge, with BCD carry: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; 59:59 -> 00:00.
REQ-015 SHALL assert rollover for exactly the one cycle in which the count becomes 00:00 from 59:59 in RUN.
REQ-016 SHALL, in PAUSE, hold all digits and ignore tick_1hz and tick_2hz.
REQ-017 SHALL, in ADJ_MIN, increment only the minutes on each tick_2hz edge, wrapping 59 -> 00 with seconds unchanged.
REQ-018 SHALL, in ADJ_SEC, increment only the seconds on each tick_2hz edge, wrapping 59 -> 00 with no carry into minutes.
REQ-019 SHALL ignore tick_1hz in both adjust states.
REQ-020 SHALL let adjust override pause: adjustment proceeds while the pause flag is set, and the pause flag is preserved.
REQ-021 SHALL, when a btn_pause edge and a tick edge occur in the same cycle, apply the tick using the pause flag value from before the toggle.
REQ-022 SHALL, on a change of adj or sel, use the new state from the next clock edge; the sub-second phase is not preserved, and the next count uses the next tick edge of the relevant rate.
REQ-023 SHALL have a latency of one clk_in cycle from the first sample of an input edge to the updated digits on the outputs (without the REQ-029 macro).
REQ-024 SHALL never output a digit outside 0-9, nor a tens digit above 5.

Reset
REQ-025 SHALL, while rst_n=0, immediately force all digits to 0, the pause flag to 0, mode to 00, rollover to 0, and all edge-detect and synchronizer registers to 0.
REQ-026 SHALL NOT detect an edge in the first cycle after rst_n deasserts if the input was already high at release; the edge registers capture the level first.
REQ-027 SHALL abort any in-progress increment when reset is asserted mid-operation, with no partial digit update.

Configuration
REQ-028 SHALL support macro STOPWATCH_INPUT_SYNC_EN.
REQ-029 SHALL, when STOPWATCH_INPUT_SYNC_EN is defined, pass tick_1hz, tick_2hz, btn_pause, adj and sel through a two-flop synchronizer before edge detection and state derivation; latency becomes three cycles.
REQ-030 SHALL, when STOPWATCH_INPUT_SYNC_EN is undefined, feed the inputs directly, with one-cycle latency per REQ-023; the function is otherwise identical.

Verification
REQ-031 SHALL cover: reset, then 60 tick_1hz edges in RUN -> 01:00; count 59:59 plus one edge -> 00:00 with a one-cycle rollover pulse.
REQ-032 SHALL cover: btn_pause edge at 00:05, then 3 tick_1hz edges -> holds 00:05 with mode=01; a second btn_pause edge plus 1 edge -> 00:06.
REQ-033 SHALL cover: adj=1, sel=0 from 58:30, then 3 tick_2hz edges -> 01:30 and mode=10; adj=1, sel=1 from 00:58, then 3 edges -> 00:01 with minutes unchanged.
REQ-034 SHALL cover: btn_pause edge and tick_1hz edge in the same cycle while in RUN at 00:10 -> 00:11 and mode=01 next.
REQ-035 SHALL cover: rst_n low mid-count at 12:34 -> all outputs 0 asynchronously; release with tick_1hz high -> no increment until the next rising edge.
REQ-036 SHALL cover: with STOPWATCH_INPUT_SYNC_EN defined, a tick_1hz edge updates the digits exactly 3 clk_in cycles after it is first sampled high.
